// File: rtl/risc_pkg.sv
// Shared definitions for the Risc core: opcode encodings, instruction field
// positions and the default halt encoding.
package risc_pkg;

    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] NOP  = 7'h00;
    localparam logic [OPC_W-1:0] MOVA = 7'h01;
    localparam logic [OPC_W-1:0] ADD  = 7'h02;
    localparam logic [OPC_W-1:0] SUB  = 7'h03;
    localparam logic [OPC_W-1:0] AND  = 7'h04;
    localparam logic [OPC_W-1:0] OR   = 7'h05;
    localparam logic [OPC_W-1:0] XOR  = 7'h06;
    localparam logic [OPC_W-1:0] NOT  = 7'h07;
    localparam logic [OPC_W-1:0] ADI  = 7'h08;
    localparam logic [OPC_W-1:0] SBI  = 7'h09;
    localparam logic [OPC_W-1:0] ANI  = 7'h0A;
    localparam logic [OPC_W-1:0] ORI  = 7'h0B;
    localparam logic [OPC_W-1:0] XRI  = 7'h0C;
    localparam logic [OPC_W-1:0] MOVB = 7'h0D;
    localparam logic [OPC_W-1:0] LSR  = 7'h0E;
    localparam logic [OPC_W-1:0] LSL  = 7'h0F;
    localparam logic [OPC_W-1:0] LD   = 7'h10;
    localparam logic [OPC_W-1:0] ST   = 7'h11;
    localparam logic [OPC_W-1:0] JMR  = 7'h12;
    localparam logic [OPC_W-1:0] SLT  = 7'h13;
    localparam logic [OPC_W-1:0] BZ   = 7'h14;
    localparam logic [OPC_W-1:0] BNZ  = 7'h15;
    localparam logic [OPC_W-1:0] JMP  = 7'h16;
    localparam logic [OPC_W-1:0] JML  = 7'h17;

    // Instruction field bit positions (inclusive).
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 25;
    localparam int unsigned DR_HI  = 24;
    localparam int unsigned DR_LO  = 20;
    localparam int unsigned SA_HI  = 19;
    localparam int unsigned SA_LO  = 15;
    localparam int unsigned SB_HI  = 14;
    localparam int unsigned SB_LO  = 10;
    localparam int unsigned IMM_HI = 14;
    localparam int unsigned IMM_LO = 0;
    localparam int unsigned SH_HI  = 4;
    localparam int unsigned SH_LO  = 0;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/risc_fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the valid/ready path
// towards decode. master = fetch stage, slave = memory/decode side.
interface risc_fetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] im_addr;
    logic              im_oen;
    logic [DATA_W-1:0] im_dataout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output im_addr, im_oen, out_valid, out_instr, out_pc,
        input  im_dataout, out_ready
    );

    modport slave (
        input  im_addr, im_oen, out_valid, out_instr, out_pc,
        output im_dataout, out_ready
    );
endinterface

// File: rtl/risc_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush empties it in
// one cycle and takes priority over push.
module risc_fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             push_ok;
    logic             pop_ok;

    // Guard against underflow/overflow; a full queue accepts a push only alongside a pop.
    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && !flush && ((count < CNT_W'(DEPTH)) || pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/risc_fetch.sv
// Instruction-fetch stage of the Risc core: issues memory reads, queues the
// responses for decode, handles redirects and the sticky halt.
// Optional FETCH_TRACE_EN: simulation trace of every pop and of the halt.
module risc_fetch
    import risc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halt,
    risc_fetch_if.master      bus
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [ADDR_W-1:0]  rsp_pc_q;
    logic               inflight_q;
    logic               halted_q;

    logic               redirect_act;
    logic               pop;
    logic [OCC_W-1:0]   occupancy;
    logic               issue;
    logic [ADDR_W-1:0]  issue_addr;
    logic               capture;
    logic               halt_set;
    logic               push;

    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;

    // Issue, capture and next-pc decisions for this cycle.
    always_comb begin
        redirect_act = redirect_valid && !halted_q;
        pop          = bus.out_valid && bus.out_ready;
        occupancy    = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
        // A redirect flushes queue and in-flight word, so space is always available.
        issue        = rst_n && en && !halted_q && (redirect_act || (occupancy < OCC_W'(DEPTH)));
        issue_addr   = redirect_act ? redirect_pc : pc_q;
        // Words returned after the halt word belong to a dead path.
        capture      = inflight_q && !halted_q && !redirect_act;
        halt_set     = capture && (bus.im_dataout == HALT_WORD);
        push         = capture && !halt_set;
        pc_d         = pc_q;
        if (issue) begin
            pc_d = issue_addr + ADDR_W'(1);
        end else if (redirect_act) begin
            pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                rsp_pc_q <= issue_addr;
            end
            if (halt_set) begin
                halted_q <= 1'b1;
            end
        end
    end

    risc_fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({rsp_pc_q, bus.im_dataout}),
        .pop       (pop),
        .flush     (redirect_act),
        .count     (count),
        .head      (head)
    );

    assign bus.im_oen    = !issue;
    assign bus.im_addr   = issue ? issue_addr : pc_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = head[ENTRY_W-1:DATA_W];
    assign bus.out_instr = head[DATA_W-1:0];
    assign halt          = halted_q;

`ifdef FETCH_TRACE_EN
    function automatic string op_name(input logic [OPC_W-1:0] op);
        case (op)
            NOP:     return "NOP";
            MOVA:    return "MOVA";
            ADD:     return "ADD";
            SUB:     return "SUB";
            AND:     return "AND";
            OR:      return "OR";
            XOR:     return "XOR";
            NOT:     return "NOT";
            ADI:     return "ADI";
            SBI:     return "SBI";
            ANI:     return "ANI";
            ORI:     return "ORI";
            XRI:     return "XRI";
            MOVB:    return "MOVB";
            LSR:     return "LSR";
            LSL:     return "LSL";
            LD:      return "LD";
            ST:      return "ST";
            JMR:     return "JMR";
            SLT:     return "SLT";
            BZ:      return "BZ";
            BNZ:     return "BNZ";
            JMP:     return "JMP";
            JML:     return "JML";
            default: return "Unknown";
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst_n && pop) begin
            $display("%0t fetch pc=%0h %s", $time, bus.out_pc,
                     op_name(bus.out_instr[OPC_HI:OPC_LO]));
        end
        if (rst_n && halt_set) begin
            $display("%0t HALT at pc %0h", $time, rsp_pc_q);
        end
    end
`endif

endmodule

// File: tb/tb_risc_fetch.sv
// Directed bench for risc_fetch: per-cycle vector tables plus hand-written
// halt and asynchronous-reset sequences against a one-cycle-latency memory.
module tb_risc_fetch;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt;

    int passed = 0;
    int total  = 0;

    risc_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    risc_fetch #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (2),
        .RESET_PC  (32'd0),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: word k at address k, data one cycle after request.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (!bus.im_oen) begin
            bus.im_dataout <= mem[bus.im_addr[5:0]];
        end
    end

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_oen;
        logic [31:0] exp_addr;
        logic        exp_halt;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic r, input logic rv,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] epc, input logic eoen,
                                input logic [31:0] eaddr, input logic eh);
        vec_t v;
        v.en = e; v.rdy = r; v.rv = rv; v.rpc = rpc;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_oen = eoen;
        v.exp_addr = eaddr; v.exp_halt = eh;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Drive one cycle's inputs just after the edge, compare mid-cycle.
    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        en             = v.en;
        bus.out_ready  = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        @(negedge clk);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            check({tag, ".pc"}, bus.out_pc, v.exp_pc);
            check({tag, ".instr"}, bus.out_instr, v.exp_pc);
        end
        check({tag, ".oen"}, 32'(bus.im_oen), 32'(v.exp_oen));
        check({tag, ".addr"}, bus.im_addr, v.exp_addr);
        check({tag, ".halt"}, 32'(halt), 32'(v.exp_halt));
    endtask

    task automatic do_reset();
        en             = 1'b0;
        redirect_valid = 1'b0;
        bus.out_ready  = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t main_tab[$];
    vec_t halt_tab[$];
    vec_t fill_tab[$];
    vec_t rest_tab[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);

        // en rdy rv rpc | valid pc oen addr halt
        main_tab.push_back(mk(1, 1, 0,  0, 0,  0, 0,  0, 0)); // c0 first request
        main_tab.push_back(mk(1, 1, 0,  0, 0,  0, 0,  1, 0));
        main_tab.push_back(mk(1, 1, 0,  0, 1,  0, 0,  2, 0)); // first valid
        main_tab.push_back(mk(1, 1, 0,  0, 1,  1, 0,  3, 0));
        main_tab.push_back(mk(1, 1, 0,  0, 1,  2, 0,  4, 0));
        main_tab.push_back(mk(1, 0, 0,  0, 1,  3, 1,  5, 0)); // backpressure
        main_tab.push_back(mk(1, 0, 0,  0, 1,  3, 1,  5, 0));
        main_tab.push_back(mk(1, 0, 0,  0, 1,  3, 1,  5, 0));
        main_tab.push_back(mk(1, 0, 0,  0, 1,  3, 1,  5, 0));
        main_tab.push_back(mk(1, 0, 0,  0, 1,  3, 1,  5, 0));
        main_tab.push_back(mk(1, 1, 0,  0, 1,  3, 0,  5, 0)); // release
        main_tab.push_back(mk(1, 1, 0,  0, 1,  4, 0,  6, 0));
        main_tab.push_back(mk(1, 1, 0,  0, 1,  5, 0,  7, 0));
        main_tab.push_back(mk(1, 1, 1, 40, 1,  6, 0, 40, 0)); // redirect, 7 in flight
        main_tab.push_back(mk(1, 1, 0,  0, 0,  0, 0, 41, 0));
        main_tab.push_back(mk(1, 1, 0,  0, 1, 40, 0, 42, 0));
        main_tab.push_back(mk(1, 1, 0,  0, 1, 41, 0, 43, 0));
        main_tab.push_back(mk(0, 1, 0,  0, 1, 42, 1, 44, 0)); // en low
        main_tab.push_back(mk(0, 1, 0,  0, 1, 43, 1, 44, 0));
        main_tab.push_back(mk(0, 1, 0,  0, 0,  0, 1, 44, 0));
        main_tab.push_back(mk(1, 1, 0,  0, 0,  0, 0, 44, 0)); // resume
        main_tab.push_back(mk(1, 1, 0,  0, 0,  0, 0, 45, 0));
        main_tab.push_back(mk(1, 1, 0,  0, 1, 44, 0, 46, 0));
        main_tab.push_back(mk(1, 1, 0,  0, 1, 45, 0, 47, 0));

        halt_tab.push_back(mk(1, 1, 0,  0, 0,  0, 0,  0, 0));
        halt_tab.push_back(mk(1, 1, 0,  0, 0,  0, 0,  1, 0));
        halt_tab.push_back(mk(1, 1, 0,  0, 1,  0, 0,  2, 0));
        halt_tab.push_back(mk(1, 1, 0,  0, 1,  1, 0,  3, 0));
        halt_tab.push_back(mk(1, 1, 0,  0, 1,  2, 0,  4, 0)); // halt word on bus
        halt_tab.push_back(mk(1, 1, 0,  0, 0,  0, 1,  5, 1));
        halt_tab.push_back(mk(1, 1, 1,  0, 0,  0, 1,  5, 1)); // redirect ignored
        halt_tab.push_back(mk(1, 1, 0,  0, 0,  0, 1,  5, 1));
        halt_tab.push_back(mk(1, 1, 0,  0, 0,  0, 1,  5, 1));

        fill_tab.push_back(mk(1, 0, 0,  0, 0,  0, 0,  0, 0));
        fill_tab.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 0));
        fill_tab.push_back(mk(1, 0, 0,  0, 1,  0, 1,  2, 0));
        fill_tab.push_back(mk(1, 0, 0,  0, 1,  0, 1,  2, 0));

        rest_tab.push_back(mk(1, 1, 0,  0, 0,  0, 0,  0, 0));
        rest_tab.push_back(mk(1, 1, 0,  0, 0,  0, 0,  1, 0));
        rest_tab.push_back(mk(1, 1, 0,  0, 1,  0, 0,  2, 0));
        rest_tab.push_back(mk(1, 1, 0,  0, 1,  1, 0,  3, 0));

        // Reset state
        do_reset();
        check("rst.valid", 32'(bus.out_valid), 32'd0);
        check("rst.oen", 32'(bus.im_oen), 32'd1);
        check("rst.addr", bus.im_addr, 32'd0);
        check("rst.halt", 32'(halt), 32'd0);

        for (int i = 0; i < main_tab.size(); i++)
            apply(main_tab[i], $sformatf("main[%0d]", i));

        // Halt word at address 3
        do_reset();
        mem[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < halt_tab.size(); i++)
            apply(halt_tab[i], $sformatf("halt[%0d]", i));

        // Asynchronous reset with a full queue and fetch enabled
        do_reset();
        mem[3] = 32'd3;
        for (int i = 0; i < fill_tab.size(); i++)
            apply(fill_tab[i], $sformatf("fill[%0d]", i));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.valid", 32'(bus.out_valid), 32'd0);
        check("async_rst.oen", 32'(bus.im_oen), 32'd1);
        check("async_rst.addr", bus.im_addr, 32'd0);
        check("async_rst.halt", 32'(halt), 32'd0);
        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < rest_tab.size(); i++)
            apply(rest_tab[i], $sformatf("restart[%0d]", i));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
